sar10b_conv_ctrl: RTL
=====================

Name: sar10b_conv_ctrl

Overview:
- Synchronous conversion sequencer for the 10-bit asynchronous SAR ADC.
- Generates the sample/convert clock CKS that drives the cyclic flag shift register and the SAR bit latches.
- Waits for the asynchronous end-of-conversion flag FINAL, then captures the 10 latched bit decisions into the CLK domain as DOUT with a one-cycle DVALID strobe.
- Supervises each conversion with a timeout and keeps a conversion counter.

Parameters:
- NBITS, 10, result width; must match the SAR bit latch count.
- SAMPLE_CYCLES, 4, CLK cycles CKS is held low per sample phase; legal range 3..255.
- CONV_TIMEOUT, 64, maximum CLK cycles in CONVERT without FINAL before abort; legal range 4..1023.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  continuous-conversion enable, level sensitive.
- FINAL  in  1  end-of-conversion flag from the cyclic flag chain; asynchronous to CLK.
- D_IN  in  NBITS  SAR bit latch outputs, MSB at [NBITS-1]; stable while CKS is high after FINAL rises.
- ERR_CLR  in  1  clears the sticky ERR flag.
- CKS  out  1  sample/convert clock: 0 = sample and clear flags, 1 = convert.
- DOUT  out  NBITS  last captured conversion result.
- DVALID  out  1  one-cycle strobe; DOUT is updated in the same cycle.
- BUSY  out  1  high in any state other than IDLE.
- TOUT  out  1  one-cycle pulse on conversion timeout.
- ERR  out  1  sticky timeout flag.
- CONV_CNT  out  16  count of successful conversions; wraps from 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE, CKS=0, DOUT=0, DVALID=0, BUSY=0, TOUT=0, ERR=0, CONV_CNT=0.
  - Synchronizer flops and all counters are cleared.
  - CKS=0 during reset keeps the flag chain cleared.
- FINAL passes through a 2-flop synchronizer to give FINAL_S. No other use of raw FINAL.
- All outputs are registered.
- States: IDLE, SAMPLE, CONVERT, CAPTURE.
- IDLE:
  - CKS=0.
  - EN=1 -> SAMPLE on the next edge.
- SAMPLE:
  - CKS=0 for exactly SAMPLE_CYCLES cycles, then -> CONVERT.
  - The minimum of 3 cycles guarantees FINAL_S has returned to 0 before CONVERT.
- CONVERT:
  - CKS=1; the timeout counter starts at 0 on entry and increments each cycle.
  - FINAL_S=1 -> CAPTURE.
  - Otherwise, when the counter reaches CONV_TIMEOUT-1 -> abort:
    - TOUT pulses for 1 cycle and ERR is set.
    - DOUT and DVALID are untouched; CONV_CNT does not increment.
    - Next state is SAMPLE if EN=1, else IDLE.
  - If FINAL_S=1 in the same cycle the timeout expires, FINAL wins: no TOUT, normal capture.
- CAPTURE:
  - CKS stays 1 so D_IN holds.
  - On the exit edge: DOUT<=D_IN, DVALID=1 for one cycle, CONV_CNT+1.
  - Next state is SAMPLE if EN=1, else IDLE; CKS falls on that same edge.
- Latency: first cycle FINAL_S=1 is cycle n; state=CAPTURE at n+1; DOUT/DVALID valid at n+2. FINAL pin to DVALID is 4 edges.
- EN sampled only in IDLE and on CAPTURE/abort exit.
  - EN falling mid-conversion: the current conversion completes and its result is delivered, then IDLE.
  - EN falling during SAMPLE has no effect until the cycle completes.
- ERR:
  - Set by timeout; cleared by ERR_CLR=1.
  - Timeout and ERR_CLR in the same cycle: set wins.
- RST asserted mid-conversion: immediate return to reset values; CKS drops to 0 asynchronously; no DVALID.
- Back-to-back throughput with EN held high: SAMPLE_CYCLES + conversion cycles + 1 (CAPTURE) per result.

Test Plan:
- Reset then EN=1, FINAL model asserts 20 cycles after CKS rises, D_IN=0x2A5 -> CKS low 4 cycles, high; DVALID single pulse 4 edges after FINAL; DOUT=0x2A5; CONV_CNT=1; BUSY=1.
- EN held high, 3 conversions with D_IN=0x000, 0x3FF, 0x155 -> three DVALID pulses with matching DOUT; CKS low exactly 4 cycles between each; CONV_CNT=3.
- FINAL never asserts -> TOUT pulse 64 cycles after CKS rises; ERR=1; DVALID never asserts; DOUT keeps prior value; CKS returns low; ERR_CLR=1 -> ERR=0.
- Timeout coincidence: FINAL_S first high on counter=63, plus ERR_CLR in a timeout cycle -> first case gives normal capture with TOUT=0; second leaves ERR=1.
- EN dropped one cycle after CKS rises -> conversion completes, DVALID asserted, then IDLE with CKS=0 and BUSY=0; no further SAMPLE.
- RST pulsed mid-CONVERT -> CKS=0 immediately; DOUT=0; CONV_CNT=0; no DVALID; with EN=1 after release, normal conversion resumes from SAMPLE.

Source files
------------

// File: rtl/sar10b_conv_ctrl.sv
// Conversion sequencer for the 10-bit asynchronous SAR ADC: generates CKS, waits for the
// synchronized FINAL flag, captures the latched bit decisions and supervises timeouts.
module sar10b_conv_ctrl #(
  parameter int NBITS         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int CONV_TIMEOUT  = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             FINAL,
  input  logic [NBITS-1:0] D_IN,
  input  logic             ERR_CLR,
  output logic             CKS,
  output logic [NBITS-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
  output logic             TOUT,
  output logic             ERR,
  output logic [15:0]      CONV_CNT,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // One phase counter serves both SAMPLE length and CONVERT timeout (max 1023).
  localparam int CW = 10;
  localparam logic [CW-1:0] SAMPLE_LAST  = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CONV_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             cks_q, cks_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             tout_q, tout_d;
  logic             err_q, err_d;
  logic [15:0]      conv_cnt_q, conv_cnt_d;
  logic             final_s;
  logic             timeout_hit;

  always_comb begin
    sync1_d = FINAL;
    sync2_d = sync1_q;
  end

  assign final_s = sync2_q;

  // Result handshake: DVALID is a single-cycle strobe with no ready; DOUT changes only
  // in the DVALID cycle and holds until the next capture, so a consumer samples DOUT
  // whenever DVALID is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    tout_d      = 1'b0;
    conv_cnt_d  = conv_cnt_q;
    timeout_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (EN) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = ST_CONVERT;
          cnt_d   = '0;
        end
      end

      ST_CONVERT: begin
        // FINAL takes priority over a timeout expiring in the same cycle.
        if (final_s) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          tout_d      = 1'b1;
          cnt_d       = '0;
          state_d     = EN ? ST_SAMPLE : ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        dout_d     = D_IN;
        dvalid_d   = 1'b1;
        conv_cnt_d = conv_cnt_q + 16'd1;
        cnt_d      = '0;
        state_d    = EN ? ST_SAMPLE : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    // CKS and BUSY follow the next state so they are registered yet aligned with it.
    cks_d  = (state_d == ST_CONVERT) || (state_d == ST_CAPTURE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cks_q      <= 1'b0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      tout_q     <= 1'b0;
      err_q      <= 1'b0;
      conv_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cks_q      <= cks_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      busy_q     <= busy_d;
      tout_q     <= tout_d;
      err_q      <= err_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  assign CKS       = cks_q;
  assign DOUT      = dout_q;
  assign DVALID    = dvalid_q;
  assign BUSY      = busy_q;
  assign TOUT      = tout_q;
  assign ERR       = err_q;
  assign CONV_CNT  = conv_cnt_q;
  assign DBG_STATE = state_q;

endmodule
